kf_spike_fanout: RTL and testbench
==================================

Name: kf_spike_fanout

Overview:
- Sits directly downstream of the tile SNN core and consumes its spike output stream (post-synaptic neuron ID plus 8-bit payload).
- Looks up each firing neuron's axon fanout list in a local routing table.
- Emits one NoC flit per destination (tile X/Y plus target presynaptic neuron ID) toward the mesh router.
- Is event-driven: fully idle and ready when no spikes arrive.

Parameters:
- NID_W, KF_NEURON_ID_BITS: neuron ID width. Both the source ID and the destination ID use it.
- N_NEURONS, KF_NEURONS_PER_TILE: number of fanout-index entries, one per local neuron.
- ROUTE_AW, 10: route-table address width; table depth is 2**ROUTE_AW.
- COORD_W, 4: mesh coordinate width per axis.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- spk_valid  in  1  spike from SNN core valid
- spk_ready  out  1  block can accept a spike
- spk_neuron_id  in  NID_W  firing local neuron
- spk_payload  in  8  context/timestamp
- flit_valid  out  1  flit to router valid
- flit_ready  in  1  router accepts flit
- flit_dest_x  out  COORD_W  destination tile X
- flit_dest_y  out  COORD_W  destination tile Y
- flit_neuron_id  out  NID_W  presynaptic ID at the destination
- flit_payload  out  8  copied from the spike
- flit_last  out  1  last flit of this spike's fanout
- cfg_we  in  1  table write strobe
- cfg_sel  in  1  table select: 0 = fanout index, 1 = route entry
- cfg_addr  in  ROUTE_AW  write address (index table uses the low NID_W bits)
- cfg_wdata  in  32  index entry {start[ROUTE_AW-1:0], count[7:0]} in bits [ROUTE_AW+7:0]; route entry {x, y, nid} in bits [2*COORD_W+NID_W-1:0]
- busy  out  1  state != IDLE
- spikes_in_cnt  out  16  accepted spikes, saturating
- flits_out_cnt  out  16  flits handed off, saturating
- unrouted_cnt  out  16  spikes with count==0, saturating

Behaviour:
- Reset values:
  - FSM returns to IDLE; spk_ready=1 after reset release.
  - flit_valid=0, all flit_* outputs=0, busy=0, all counters=0.
  - Table contents are not reset; they are BRAM and retain their data.
- Reset mid-fanout: the in-flight spike and its remaining flits are discarded; no partial recovery.
- States:
  - IDLE: spk_ready=1. On spk_valid, latch the ID and payload, increment spikes_in_cnt, go to LOOKUP.
  - LOOKUP: synchronous read of index[id]; latch start and count; set remaining=count.
    - If count==0: increment unrouted_cnt, go to IDLE.
    - Otherwise go to FETCH.
  - FETCH: synchronous read of route[ptr], with ptr=start initially; go to SEND.
  - SEND: flit_valid=1; flit_last=(remaining==1). On flit_ready:
    - increment flits_out_cnt;
    - ptr=ptr+1, wrapping modulo 2**ROUTE_AW;
    - decrement remaining;
    - go to IDLE if remaining was 1, else go to FETCH.
- Handshake: flit_* outputs hold stable while flit_valid && !flit_ready. flit_valid never drops without a handshake except on reset.
- Latency: spike accepted at cycle 0 gives flit_valid at cycle 3 at the earliest. Throughput is one flit per 2 cycles with no backpressure.
- spk_ready=0 in every state except IDLE; the SNN core's own FIFO absorbs the stall.
- Fanout of 1..255 destinations per spike; count=255 is legal.
- A range wrapping past the end of the table (e.g. start=1022, count=3 → 1022, 1023, 0) is legal.
- Config writes are accepted in any state. A write to the same address as the same-cycle read returns the old data; the new data is visible from the next read.
- Counters saturate at 16'hFFFF; they do not wrap.
- Destinations equal to the local tile are emitted normally; the router handles loopback.

Decomposition:
- Add to kf_pkg:
  - fanout_idx_t {start, count};
  - route_entry_t {dest_x, dest_y, nid};
  - kf_flit_t;
  - ROUTE_AW and COORD_W defaults.
- One sub-module, kf_route_ram: a single-port-write / single-port-read synchronous RAM, parameterized by width and depth. Instantiate it twice, once for the index table and once for the route table.

Test Plan:
- Index[5]={start=10,count=3}, routes 10..12 = (1,2,7),(3,0,9),(0,0,1); spike id=5 payload=0xA5 with flit_ready=1 → 3 flits in that order, payload 0xA5, flit_last only on the third; flits_out_cnt=3; spk_ready high again after the last handshake.
- Index[2].count=0; spike id=2 → no flit, unrouted_cnt=1, spk_ready back after 2 cycles.
- Fanout of 2 with flit_ready held low for 5 cycles on the first flit → outputs stable for all 5 cycles, exactly 2 flits total, no duplicate.
- start=1022, count=3 → flits read from route addresses 1022, 1023, 0.
- Assert rst_n low during the second flit of a 4-flit fanout → flit_valid=0 and counters=0 immediately; after release a new spike produces its full fanout correctly, and table contents are intact.
- Preload spikes_in_cnt to 16'hFFFE (or issue 65,537 spikes) → counter holds at 16'hFFFF.

Source files
------------

// File: rtl/kf_pkg.sv
// kf_pkg: shared widths, table entry layouts, FSM encodings and counter helper for the spike fanout block
package kf_pkg;

    localparam int KF_NEURON_ID_BITS   = 8;
    localparam int KF_NEURONS_PER_TILE = 256;
    localparam int KF_ROUTE_AW         = 10;
    localparam int KF_COORD_W          = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOOKUP = 2'd1;
    localparam logic [1:0] ST_FETCH  = 2'd2;
    localparam logic [1:0] ST_SEND   = 2'd3;

    typedef struct packed {
        logic [KF_ROUTE_AW-1:0] start;
        logic [7:0]             count;
    } fanout_idx_t;

    typedef struct packed {
        logic [KF_COORD_W-1:0]        dest_x;
        logic [KF_COORD_W-1:0]        dest_y;
        logic [KF_NEURON_ID_BITS-1:0] nid;
    } route_entry_t;

    typedef struct packed {
        logic [KF_COORD_W-1:0]        dest_x;
        logic [KF_COORD_W-1:0]        dest_y;
        logic [KF_NEURON_ID_BITS-1:0] nid;
        logic [7:0]                   payload;
        logic                         last;
    } kf_flit_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/kf_route_ram.sv
// kf_route_ram: one write port, one registered read port; a same-address read returns the pre-write data
module kf_route_ram #(
    parameter int W     = 32,
    parameter int AW    = 10,
    parameter int DEPTH = 2**AW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Write and read share the edge; non-blocking update gives read-before-write
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/kf_spike_fanout.sv
// kf_spike_fanout: expands each accepted spike into one NoC flit per routing-table destination
module kf_spike_fanout
    import kf_pkg::*;
#(
    parameter int NID_W     = KF_NEURON_ID_BITS,
    parameter int N_NEURONS = KF_NEURONS_PER_TILE,
    parameter int ROUTE_AW  = KF_ROUTE_AW,
    parameter int COORD_W   = KF_COORD_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                spk_valid,
    output logic                spk_ready,
    input  logic [NID_W-1:0]    spk_neuron_id,
    input  logic [7:0]          spk_payload,
    output logic                flit_valid,
    input  logic                flit_ready,
    output logic [COORD_W-1:0]  flit_dest_x,
    output logic [COORD_W-1:0]  flit_dest_y,
    output logic [NID_W-1:0]    flit_neuron_id,
    output logic [7:0]          flit_payload,
    output logic                flit_last,
    input  logic                cfg_we,
    input  logic                cfg_sel,
    input  logic [ROUTE_AW-1:0] cfg_addr,
    input  logic [31:0]         cfg_wdata,
    output logic                busy,
    output logic [15:0]         spikes_in_cnt,
    output logic [15:0]         flits_out_cnt,
    output logic [15:0]         unrouted_cnt
);

    localparam int IW = ROUTE_AW + 8;
    localparam int RW = 2*COORD_W + NID_W;

    logic [1:0]          state_q, state_d;
    logic [ROUTE_AW-1:0] ptr_q, ptr_d;
    logic [7:0]          rem_q, rem_d;
    logic [7:0]          payload_q, payload_d;
    logic [15:0]         spikes_in_q, spikes_in_d;
    logic [15:0]         flits_out_q, flits_out_d;
    logic [15:0]         unrouted_q, unrouted_d;
    logic [IW-1:0]       idx_rdata;
    logic [RW-1:0]       route_rdata;
    logic                idx_re, route_re, send;
    logic                unused_cfg;

    assign unused_cfg = ^{cfg_addr[ROUTE_AW-1:NID_W], cfg_wdata[31:IW]};

    // Index read launches on the accepting edge so start/count are ready during LOOKUP
    assign idx_re   = (state_q == ST_IDLE) && spk_valid;
    assign route_re = (state_q == ST_FETCH);

    kf_route_ram #(.W(IW), .AW(NID_W), .DEPTH(N_NEURONS)) u_idx (
        .clk   (clk),
        .we    (cfg_we && !cfg_sel),
        .waddr (cfg_addr[NID_W-1:0]),
        .wdata (cfg_wdata[IW-1:0]),
        .re    (idx_re),
        .raddr (spk_neuron_id),
        .rdata (idx_rdata)
    );

    kf_route_ram #(.W(RW), .AW(ROUTE_AW), .DEPTH(2**ROUTE_AW)) u_route (
        .clk   (clk),
        .we    (cfg_we && cfg_sel),
        .waddr (cfg_addr),
        .wdata (cfg_wdata[RW-1:0]),
        .re    (route_re),
        .raddr (ptr_q),
        .rdata (route_rdata)
    );

    // The route RAM output is only re-read in FETCH, so it holds steady through backpressure
    assign send           = (state_q == ST_SEND);
    assign spk_ready      = (state_q == ST_IDLE);
    assign busy           = !spk_ready;
    assign flit_valid     = send;
    assign flit_last      = send && (rem_q == 8'd1);
    assign flit_dest_x    = send ? route_rdata[RW-1 -: COORD_W] : '0;
    assign flit_dest_y    = send ? route_rdata[NID_W +: COORD_W] : '0;
    assign flit_neuron_id = send ? route_rdata[NID_W-1:0] : '0;
    assign flit_payload   = send ? payload_q : '0;
    assign spikes_in_cnt  = spikes_in_q;
    assign flits_out_cnt  = flits_out_q;
    assign unrouted_cnt   = unrouted_q;

    // Next-state: walk the fanout range one destination per FETCH/SEND pair
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        payload_d   = payload_q;
        spikes_in_d = spikes_in_q;
        flits_out_d = flits_out_q;
        unrouted_d  = unrouted_q;
        case (state_q)
            ST_IDLE: if (spk_valid) begin
                payload_d   = spk_payload;
                spikes_in_d = sat_inc(spikes_in_q);
                state_d     = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                ptr_d      = idx_rdata[IW-1:8];
                rem_d      = idx_rdata[7:0];
                unrouted_d = (idx_rdata[7:0] == 8'd0) ? sat_inc(unrouted_q) : unrouted_q;
                state_d    = (idx_rdata[7:0] == 8'd0) ? ST_IDLE : ST_FETCH;
            end
            ST_FETCH: state_d = ST_SEND;
            default: if (flit_ready) begin
                flits_out_d = sat_inc(flits_out_q);
                ptr_d       = ptr_q + ROUTE_AW'(1);
                rem_d       = rem_q - 8'd1;
                state_d     = (rem_q == 8'd1) ? ST_IDLE : ST_FETCH;
            end
        endcase
    end

    // State and counters; reset drops any in-flight fanout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            rem_q       <= '0;
            payload_q   <= '0;
            spikes_in_q <= '0;
            flits_out_q <= '0;
            unrouted_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rem_q       <= rem_d;
            payload_q   <= payload_d;
            spikes_in_q <= spikes_in_d;
            flits_out_q <= flits_out_d;
            unrouted_q  <= unrouted_d;
        end
    end

endmodule

// File: tb/tb_kf_spike_fanout.sv
// tb_kf_spike_fanout: directed spikes with a flit scoreboard checked by an independent monitor
module tb_kf_spike_fanout;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        spk_valid, spk_ready;
    logic [7:0]  spk_neuron_id, spk_payload;
    logic        flit_valid, flit_ready;
    logic [3:0]  flit_dest_x, flit_dest_y;
    logic [7:0]  flit_neuron_id, flit_payload;
    logic        flit_last;
    logic        cfg_we, cfg_sel;
    logic [9:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        busy;
    logic [15:0] spikes_in_cnt, flits_out_cnt, unrouted_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [24:0] exp_q[$];

    kf_spike_fanout dut (
        .clk(clk), .rst_n(rst_n),
        .spk_valid(spk_valid), .spk_ready(spk_ready),
        .spk_neuron_id(spk_neuron_id), .spk_payload(spk_payload),
        .flit_valid(flit_valid), .flit_ready(flit_ready),
        .flit_dest_x(flit_dest_x), .flit_dest_y(flit_dest_y),
        .flit_neuron_id(flit_neuron_id), .flit_payload(flit_payload),
        .flit_last(flit_last),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .busy(busy),
        .spikes_in_cnt(spikes_in_cnt), .flits_out_cnt(flits_out_cnt), .unrouted_cnt(unrouted_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic sel, input logic [9:0] addr, input logic [31:0] data);
        cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_wdata = data;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic set_index(input logic [7:0] id, input logic [9:0] start, input logic [7:0] cnt);
        cfg_write(1'b0, {2'b0, id}, {14'b0, start, cnt});
    endtask

    task automatic set_route(input logic [9:0] addr, input logic [3:0] x, input logic [3:0] y, input logic [7:0] nid);
        cfg_write(1'b1, addr, {16'b0, x, y, nid});
    endtask

    task automatic push(input logic [3:0] x, input logic [3:0] y, input logic [7:0] nid, input logic [7:0] pl, input logic last);
        exp_q.push_back({x, y, nid, pl, last});
    endtask

    task automatic send_spike(input logic [7:0] id, input logic [7:0] pl);
        int n = 0;
        spk_valid = 1'b1; spk_neuron_id = id; spk_payload = pl;
        while (!spk_ready && n < 100) begin tick(); n++; end
        check("spk_ready_before_accept", {31'b0, spk_ready}, 32'd1);
        tick();
        spk_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 2000) begin tick(); n++; end
        check(name, {31'b0, busy}, 32'd0);
    endtask

    // Monitor: every presented flit must match the scoreboard head; pop on handshake
    always @(negedge clk) begin
        if (rst_n && flit_valid) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_flit: got x=%0d y=%0d nid=0x%0h with empty scoreboard", flit_dest_x, flit_dest_y, flit_neuron_id);
            end else begin
                check("flit", {7'b0, flit_dest_x, flit_dest_y, flit_neuron_id, flit_payload, flit_last}, {7'b0, exp_q[0]});
                if (flit_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; spk_valid = 1'b0; spk_neuron_id = '0; spk_payload = '0;
        flit_ready = 1'b1; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("reset_spk_ready", {31'b0, spk_ready}, 32'd1);
        check("reset_flit_valid", {31'b0, flit_valid}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_flit_fields", {7'b0, flit_dest_x, flit_dest_y, flit_neuron_id, flit_payload, flit_last}, 32'd0);
        check("reset_counters", {spikes_in_cnt, flits_out_cnt | unrouted_cnt}, 32'd0);

        set_index(8'd5, 10'd10, 8'd3);
        set_route(10'd10, 4'd1, 4'd2, 8'd7);
        set_route(10'd11, 4'd3, 4'd0, 8'd9);
        set_route(10'd12, 4'd0, 4'd0, 8'd1);
        set_index(8'd2, 10'd0, 8'd0);
        set_index(8'd7, 10'd20, 8'd2);
        set_route(10'd20, 4'd5, 4'd6, 8'h11);
        set_route(10'd21, 4'd7, 4'd8, 8'h22);
        set_index(8'd9, 10'd1022, 8'd3);
        set_route(10'd1022, 4'd9, 4'd10, 8'h33);
        set_route(10'd1023, 4'd11, 4'd12, 8'h44);
        set_route(10'd0, 4'd13, 4'd14, 8'h55);
        set_index(8'd11, 10'd30, 8'd4);
        set_route(10'd30, 4'd1, 4'd1, 8'h61);
        set_route(10'd31, 4'd2, 4'd2, 8'h62);
        set_route(10'd32, 4'd3, 4'd3, 8'h63);
        set_route(10'd33, 4'd4, 4'd4, 8'h64);

        // Three-destination fanout, first flit at cycle 3
        push(4'd1, 4'd2, 8'd7, 8'hA5, 1'b0);
        push(4'd3, 4'd0, 8'd9, 8'hA5, 1'b0);
        push(4'd0, 4'd0, 8'd1, 8'hA5, 1'b1);
        send_spike(8'd5, 8'hA5);
        check("lat_cycle1_valid", {31'b0, flit_valid}, 32'd0);
        tick();
        check("lat_cycle2_valid", {31'b0, flit_valid}, 32'd0);
        tick();
        check("lat_cycle3_valid", {31'b0, flit_valid}, 32'd1);
        wait_idle("fanout3_idle");
        check("fanout3_flits_out", {16'b0, flits_out_cnt}, 32'd3);
        check("fanout3_spk_ready", {31'b0, spk_ready}, 32'd1);
        check("fanout3_spikes_in", {16'b0, spikes_in_cnt}, 32'd1);
        check("fanout3_drained", exp_q.size(), 32'd0);

        // Empty fanout: no flit, ready two cycles after acceptance
        send_spike(8'd2, 8'h01);
        check("unrouted_cycle1_ready", {31'b0, spk_ready}, 32'd0);
        tick();
        check("unrouted_cycle2_ready", {31'b0, spk_ready}, 32'd1);
        check("unrouted_cnt", {16'b0, unrouted_cnt}, 32'd1);
        check("unrouted_no_flit", {16'b0, flits_out_cnt}, 32'd3);

        // Backpressure: hold the first flit for five cycles
        flit_ready = 1'b0;
        push(4'd5, 4'd6, 8'h11, 8'h3C, 1'b0);
        push(4'd7, 4'd8, 8'h22, 8'h3C, 1'b1);
        send_spike(8'd7, 8'h3C);
        tick();
        tick();
        repeat (5) tick();
        check("stall_still_valid", {31'b0, flit_valid}, 32'd1);
        check("stall_no_handshake", {16'b0, flits_out_cnt}, 32'd3);
        flit_ready = 1'b1;
        wait_idle("stall_idle");
        check("stall_flits_out", {16'b0, flits_out_cnt}, 32'd5);
        check("stall_drained", exp_q.size(), 32'd0);

        // Range wrapping past the top of the route table
        push(4'd9, 4'd10, 8'h33, 8'h5A, 1'b0);
        push(4'd11, 4'd12, 8'h44, 8'h5A, 1'b0);
        push(4'd13, 4'd14, 8'h55, 8'h5A, 1'b1);
        send_spike(8'd9, 8'h5A);
        wait_idle("wrap_idle");
        check("wrap_flits_out", {16'b0, flits_out_cnt}, 32'd8);
        check("wrap_drained", exp_q.size(), 32'd0);

        // Reset while the second of four flits is presented
        push(4'd1, 4'd1, 8'h61, 8'h77, 1'b0);
        push(4'd2, 4'd2, 8'h62, 8'h77, 1'b0);
        push(4'd3, 4'd3, 8'h63, 8'h77, 1'b0);
        push(4'd4, 4'd4, 8'h64, 8'h77, 1'b1);
        send_spike(8'd11, 8'h77);
        repeat (4) tick();
        check("rst_mid_second_flit_valid", {31'b0, flit_valid}, 32'd1);
        check("rst_mid_second_flit_nid", {24'b0, flit_neuron_id}, 32'h62);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("rst_mid_flit_valid", {31'b0, flit_valid}, 32'd0);
        check("rst_mid_flit_fields", {7'b0, flit_dest_x, flit_dest_y, flit_neuron_id, flit_payload, flit_last}, 32'd0);
        check("rst_mid_counters", {spikes_in_cnt, flits_out_cnt | unrouted_cnt}, 32'd0);
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        push(4'd1, 4'd1, 8'h61, 8'h78, 1'b0);
        push(4'd2, 4'd2, 8'h62, 8'h78, 1'b0);
        push(4'd3, 4'd3, 8'h63, 8'h78, 1'b0);
        push(4'd4, 4'd4, 8'h64, 8'h78, 1'b1);
        send_spike(8'd11, 8'h78);
        wait_idle("post_rst_idle");
        check("post_rst_flits_out", {16'b0, flits_out_cnt}, 32'd4);
        check("post_rst_spikes_in", {16'b0, spikes_in_cnt}, 32'd1);
        check("post_rst_drained", exp_q.size(), 32'd0);

        // Saturation of the accepted-spike counter
        force dut.spikes_in_q = 16'hFFFE;
        tick();
        release dut.spikes_in_q;
        check("sat_preload", {16'b0, spikes_in_cnt}, 32'hFFFE);
        send_spike(8'd2, 8'h00);
        tick();
        check("sat_reach_max", {16'b0, spikes_in_cnt}, 32'hFFFF);
        send_spike(8'd2, 8'h00);
        tick();
        check("sat_hold_max", {16'b0, spikes_in_cnt}, 32'hFFFF);
        check("sat_unrouted", {16'b0, unrouted_cnt}, 32'd2);
        check("final_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
